// File: rtl/rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// rst_seq_pkg
// Shared definitions for the reset sequencing controller (rst_seq_ctrl).
//   seq_state_e     : sequencer FSM state (IDLE, HOLD, RELEASE, DONE)
//   ACK_TIMEOUT_CYC : wait length after which ACK_TIMEOUT is flagged
//   ACK_CNT_W       : width of the acknowledge-wait timer
//   clog2()         : ceiling log2, used for the STAGE_IDX width
// -----------------------------------------------------------------------------
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } seq_state_e;

    localparam int ACK_TIMEOUT_CYC = 255;
    localparam int ACK_CNT_W       = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// -----------------------------------------------------------------------------
// rst_seq_timer
// CNT_W-bit up-counter with synchronous clear, count enable and a terminal
// count compare. The count saturates at the terminal value and never wraps.
// Ports:
//   CLK      in  clock
//   RST      in  asynchronous active-low reset (count = 0)
//   clr_i    in  synchronous clear (wins over en_i)
//   en_i     in  count enable
//   tc_val_i in  terminal count value
//   tc_o     out high while the count equals tc_val_i
// -----------------------------------------------------------------------------
module rst_seq_timer #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] tc_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o = (cnt_q == tc_val_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rst_seq_ctrl
// Reset sequencing controller. Holds all domain resets asserted for HOLD_CYC
// cycles after reset release (or a software restart), then releases domain 0,
// 1, ... NUM_DOMAINS-1 one at a time, RELEASE_DLY cycles apart.
// Optional feature macro: RST_SEQ_ACK_EN (acknowledge-gated release).
// Ports:
//   CLK          in  sequencer clock
//   RST          in  asynchronous active-low reset
//   SW_RST_REQ   in  software restart request (ignored in IDLE)
//   DOM_ACK      in  per-domain release acknowledge (RST_SEQ_ACK_EN only)
//   ACK_TIMEOUT  out sticky acknowledge-wait timeout (RST_SEQ_ACK_EN only)
//   DOM_RST_N    out per-domain active-low resets, bit k = domain k
//   STAGE_IDX    out number of domains released
//   SEQ_DONE     out all domains released
//   SEQ_BUSY     out sequencer in HOLD or RELEASE
//   DBG_STATE    out current FSM state
// -----------------------------------------------------------------------------
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYC    = 8,
    parameter int RELEASE_DLY = 16,
    parameter int CNT_W       = 8
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                SW_RST_REQ,
`ifdef RST_SEQ_ACK_EN
    input  logic [NUM_DOMAINS-1:0]              DOM_ACK,
    output logic                                ACK_TIMEOUT,
`endif
    output logic [NUM_DOMAINS-1:0]              DOM_RST_N,
    output logic [clog2(NUM_DOMAINS+1)-1:0]     STAGE_IDX,
    output logic                                SEQ_DONE,
    output logic                                SEQ_BUSY,
    output seq_state_e                          DBG_STATE
);

    localparam int SW = clog2(NUM_DOMAINS + 1);

    generate
        if (NUM_DOMAINS < 2 || NUM_DOMAINS > 8 || SYNC_STAGES < 2 ||
            HOLD_CYC < 1 || RELEASE_DLY < 1 || CNT_W < 1 || CNT_W > 30 ||
            HOLD_CYC >= (1 << CNT_W) || RELEASE_DLY >= (1 << CNT_W)) begin : g_bad_param
            $error("rst_seq_ctrl: illegal parameter set (CNT_W too small or out-of-range value)");
        end
    endgenerate

    // The FSM state register is the last synchronizer stage: the explicit
    // chain is SYNC_STAGES-1 flops and IDLE is left on the edge that would
    // have loaded the final stage.
    localparam logic [SYNC_STAGES-2:0] SYNC_ONE = (SYNC_STAGES-1)'(1);

    logic [SYNC_STAGES-2:0] rst_sync_q;
    logic                   sync_out;

    seq_state_e             state_q, state_d;
    logic [NUM_DOMAINS-1:0] dom_rst_n_q, dom_rst_n_d;
    logic [NUM_DOMAINS-1:0] rel_mask;
    logic [SW-1:0]          stage_q, stage_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;

    logic                   tmr_clr, tmr_en, tmr_tc;
    logic [CNT_W-1:0]       tmr_tc_val;
    logic                   prev_ack;
    logic                   sw_restart;
    logic                   release_go;

`ifdef RST_SEQ_ACK_EN
    logic [NUM_DOMAINS-1:0] ack_meta_q, ack_sync_q;
    logic                   ack_wait, wait_tc;
    logic                   timeout_q, timeout_d;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= (rst_sync_q << 1) | SYNC_ONE;
        end
    end

    assign sync_out = rst_sync_q[SYNC_STAGES-2];

    // One-hot of the next domain to release and the ack of the one before it.
    always_comb begin
        rel_mask = '0;
        for (int k = 0; k < NUM_DOMAINS; k++) begin
            if (stage_q == SW'(k)) begin
                rel_mask[k] = 1'b1;
            end
        end
`ifdef RST_SEQ_ACK_EN
        prev_ack = 1'b0;
        for (int k = 0; k < NUM_DOMAINS - 1; k++) begin
            if (stage_q == SW'(k + 1)) begin
                prev_ack = ack_sync_q[k];
            end
        end
`else
        prev_ack = 1'b1;
`endif
    end

    assign sw_restart = SW_RST_REQ && (state_q != ST_IDLE);
    assign release_go = (state_q == ST_RELEASE) && tmr_tc && prev_ack;
    assign tmr_tc_val = (state_q == ST_HOLD) ? CNT_W'(HOLD_CYC - 1)
                                             : CNT_W'(RELEASE_DLY - 1);

    always_comb begin
        state_d     = state_q;
        dom_rst_n_d = dom_rst_n_q;
        stage_d     = stage_q;
        done_d      = done_q;
        busy_d      = busy_q;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmr_clr = 1'b1;
                if (sync_out) begin
                    state_d = ST_HOLD;
                    busy_d  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (tmr_tc) begin
                    state_d     = ST_RELEASE;
                    dom_rst_n_d = NUM_DOMAINS'(1);
                    stage_d     = SW'(1);
                    tmr_clr     = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_RELEASE: begin
                // While waiting on an ack the timer sits at its terminal count.
                tmr_en = 1'b1;
                if (release_go) begin
                    dom_rst_n_d = dom_rst_n_q | rel_mask;
                    stage_d     = stage_q + SW'(1);
                    tmr_clr     = 1'b1;
                    if (stage_q == SW'(NUM_DOMAINS - 1)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                tmr_clr = 1'b1;
            end
        endcase
        // Restart overrides everything; a held request parks HOLD at zero.
        if (sw_restart) begin
            state_d     = ST_HOLD;
            dom_rst_n_d = '0;
            stage_d     = '0;
            done_d      = 1'b0;
            busy_d      = 1'b1;
            tmr_clr     = 1'b1;
            tmr_en      = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            dom_rst_n_q <= '0;
            stage_q     <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dom_rst_n_q <= dom_rst_n_d;
            stage_q     <= stage_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    rst_seq_timer #(
        .CNT_W(CNT_W)
    ) u_seq_timer (
        .CLK     (CLK),
        .RST     (RST),
        .clr_i   (tmr_clr),
        .en_i    (tmr_en),
        .tc_val_i(tmr_tc_val),
        .tc_o    (tmr_tc)
    );

`ifdef RST_SEQ_ACK_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ack_meta_q <= '0;
            ack_sync_q <= '0;
        end else begin
            ack_meta_q <= DOM_ACK;
            ack_sync_q <= ack_meta_q;
        end
    end

    // Waiting means the release delay is spent but the previous domain
    // has not acknowledged yet.
    assign ack_wait = (state_q == ST_RELEASE) && tmr_tc && !prev_ack;

    rst_seq_timer #(
        .CNT_W(ACK_CNT_W)
    ) u_ack_timer (
        .CLK     (CLK),
        .RST     (RST),
        .clr_i   (!ack_wait),
        .en_i    (ack_wait),
        .tc_val_i(ACK_CNT_W'(ACK_TIMEOUT_CYC)),
        .tc_o    (wait_tc)
    );

    assign timeout_d = sw_restart ? 1'b0 : (timeout_q | (ack_wait & wait_tc));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign ACK_TIMEOUT = timeout_q;
`endif

    assign DOM_RST_N = dom_rst_n_q;
    assign STAGE_IDX = stage_q;
    assign SEQ_DONE  = done_q;
    assign SEQ_BUSY  = busy_q;
    assign DBG_STATE = state_q;

endmodule
